// File: rtl/ppu_sched.sv
// ppu_sched: front-end controller for the PPU input port.
//
// Arbitrates two byte requesters (host stream on port 0, aux seed source on port 1) onto the
// PPU's single stb/ack handshake using round-robin. It also owns the PPU mode select, changing
// it only on sync (frame start) cycles. The mode can auto-cycle with a programmable dwell or be
// overridden by a host write.
//
// Optional feature macro: PPU_SCHED_TIMEOUT_EN
//   defined   - WAIT gives up after TIMEOUT cycles without ppu_ack and sets the sticky err flag.
//   undefined - WAIT holds until ppu_ack; err is tied low and err_clr is ignored.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   sync                one-cycle frame-start pulse
//   data0/stb0/ack0     requester 0 (host) byte, strobe, accept pulse
//   data1/stb1/ack1     requester 1 (aux) byte, strobe, accept pulse
//   ppu_data/ppu_stb    byte and one-cycle strobe to the PPU
//   ppu_ack             PPU accept (sampled only while waiting)
//   mode                PPU mode select
//   auto_en/dwell       auto mode cycling enable and frames per mode (0 behaves as 1)
//   mode_wr/mode_wdata  host mode write, applied at the next sync
//   err/err_clr         sticky timeout flag and its clear
module ppu_sched #(
   parameter int unsigned MODE_LAST = 5,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sync,
   input  logic [7:0] data0,
   input  logic       stb0,
   output logic       ack0,
   input  logic [7:0] data1,
   input  logic       stb1,
   output logic       ack1,
   output logic [7:0] ppu_data,
   output logic       ppu_stb,
   input  logic       ppu_ack,
   output logic [2:0] mode,
   input  logic       auto_en,
   input  logic [7:0] dwell,
   input  logic       mode_wr,
   input  logic [2:0] mode_wdata,
   output logic       err,
   input  logic       err_clr
);

   typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

   state_e     state_q, state_d;
   logic       last_q, last_d;     // last granted requester
   logic       gnt_q, gnt_d;       // requester owning the current transfer
   logic [7:0] ppu_data_q, ppu_data_d;
   logic       ppu_stb_q, ppu_stb_d;
   logic       ack0_q, ack0_d;
   logic       ack1_q, ack1_d;
   logic       gnt_sel;
   logic       timeout;

   logic [2:0] mode_q, mode_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       pend_vld_q, pend_vld_d;
   logic [2:0] pend_q, pend_d;
   logic [7:0] dwell_last;

`ifdef PPU_SCHED_TIMEOUT_EN
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       err_q, err_d;

   // wait_cnt_q counts completed WAIT cycles; the last allowed one is TIMEOUT-1.
   assign timeout = (wait_cnt_q == 8'(TIMEOUT - 1));
   assign err     = err_q;
`else
   logic unused_cfg;

   assign timeout    = 1'b0;
   assign err        = 1'b0;
   assign unused_cfg = ^{err_clr, 8'(TIMEOUT)};
`endif

   // Transfer FSM and arbitration
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      ppu_data_d = ppu_data_q;
      ppu_stb_d  = 1'b0;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      gnt_sel    = (stb0 && stb1) ? ~last_q : stb1;
`ifdef PPU_SCHED_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      err_d      = err_clr ? 1'b0 : err_q;
`endif
      case (state_q)
         StIdle: begin
            if (stb0 || stb1) begin
               gnt_d      = gnt_sel;
               last_d     = gnt_sel;
               ppu_data_d = gnt_sel ? data1 : data0;
               ppu_stb_d  = 1'b1;
               state_d    = StSend;
            end
         end
         StSend: begin
            state_d = StWait;
`ifdef PPU_SCHED_TIMEOUT_EN
            wait_cnt_d = 8'd0;
`endif
         end
         StWait: begin
            if (ppu_ack || timeout) begin
               // A timed-out byte is dropped but the requester is still released.
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
               state_d = StDone;
`ifdef PPU_SCHED_TIMEOUT_EN
               if (!ppu_ack) begin
                  err_d = 1'b1;
               end
`endif
            end else begin
`ifdef PPU_SCHED_TIMEOUT_EN
               wait_cnt_d = wait_cnt_q + 8'd1;
`endif
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Mode sequencing; mode only ever moves on a sync cycle
   always_comb begin
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      pend_vld_d  = pend_vld_q;
      pend_d      = pend_q;
      dwell_last  = (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;

      // 3-bit write data is already within the 0..7 clamp range.
      if (mode_wr) begin
         pend_vld_d = 1'b1;
         pend_d     = mode_wdata;
      end

      if (sync) begin
         if (mode_wr || pend_vld_q) begin
            // A write coincident with sync takes effect at that same sync.
            mode_d      = mode_wr ? mode_wdata : pend_q;
            frame_cnt_d = 8'd0;
            pend_vld_d  = 1'b0;
         end else if (auto_en && (frame_cnt_q >= dwell_last)) begin
            // >= also wraps host-written modes above MODE_LAST.
            mode_d      = (mode_q >= 3'(MODE_LAST)) ? 3'd0 : mode_q + 3'd1;
            frame_cnt_d = 8'd0;
         end else if (frame_cnt_q != 8'hFF) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         gnt_q       <= 1'b0;
         ppu_data_q  <= 8'd0;
         ppu_stb_q   <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         mode_q      <= 3'd0;
         frame_cnt_q <= 8'd0;
         pend_vld_q  <= 1'b0;
         pend_q      <= 3'd0;
`ifdef PPU_SCHED_TIMEOUT_EN
         wait_cnt_q  <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         ppu_data_q  <= ppu_data_d;
         ppu_stb_q   <= ppu_stb_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         pend_vld_q  <= pend_vld_d;
         pend_q      <= pend_d;
`ifdef PPU_SCHED_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign ppu_data = ppu_data_q;
   assign ppu_stb  = ppu_stb_q;
   assign mode     = mode_q;

endmodule

// File: tb/tb_ppu_sched.sv
// Directed self-checking bench for ppu_sched: reset values, single transfer latency, round-robin
// contention, timeout (or indefinite WAIT without PPU_SCHED_TIMEOUT_EN), reset during WAIT,
// auto mode cycling and host mode override.
module tb_ppu_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sync = 1'b0;
   logic [7:0] data0 = 8'd0;
   logic       stb0 = 1'b0;
   logic       ack0;
   logic [7:0] data1 = 8'd0;
   logic       stb1 = 1'b0;
   logic       ack1;
   logic [7:0] ppu_data;
   logic       ppu_stb;
   logic       ppu_ack = 1'b0;
   logic [2:0] mode;
   logic       auto_en = 1'b0;
   logic [7:0] dwell = 8'd0;
   logic       mode_wr = 1'b0;
   logic [2:0] mode_wdata = 3'd0;
   logic       err;
   logic       err_clr = 1'b0;

   ppu_sched #(
      .MODE_LAST(5),
      .TIMEOUT  (16)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .sync      (sync),
      .data0     (data0),
      .stb0      (stb0),
      .ack0      (ack0),
      .data1     (data1),
      .stb1      (stb1),
      .ack1      (ack1),
      .ppu_data  (ppu_data),
      .ppu_stb   (ppu_stb),
      .ppu_ack   (ppu_ack),
      .mode      (mode),
      .auto_en   (auto_en),
      .dwell     (dwell),
      .mode_wr   (mode_wr),
      .mode_wdata(mode_wdata),
      .err       (err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and checks happen 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // PPU model: acks for one cycle, starting the cycle after it sees ppu_stb.
   logic ack_en = 1'b0;
   logic stb_d1 = 1'b0;
   initial forever begin
      @(negedge clk);
      ppu_ack = ack_en && stb_d1;
      stb_d1  = ppu_stb;
   end

   // Monitor at 2 time units after each edge; cyc is the index of the current cycle.
   int         cyc = 0;
   int         stb_cyc, ack0_cyc, n_stb, n_ack0, n_ack1, n_both, stb_run, stb_run_max;
   logic [7:0] mon_data[$];
   int         mon_gnt[$];

   task automatic clear_mon();
      n_stb = 0; n_ack0 = 0; n_ack1 = 0; n_both = 0; stb_run = 0; stb_run_max = 0;
      stb_cyc = 0; ack0_cyc = 0;
      mon_data.delete();
      mon_gnt.delete();
   endtask

   initial forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (ppu_stb === 1'b1) begin
         n_stb++;
         stb_cyc = cyc;
         mon_data.push_back(ppu_data);
         stb_run++;
         if (stb_run > stb_run_max) stb_run_max = stb_run;
      end else begin
         stb_run = 0;
      end
      if (ack0 === 1'b1) begin
         n_ack0++;
         ack0_cyc = cyc;
         mon_gnt.push_back(0);
      end
      if (ack1 === 1'b1) begin
         n_ack1++;
         mon_gnt.push_back(1);
      end
      if (ack0 === 1'b1 && ack1 === 1'b1) n_both++;
   end

   // Requester: holds stb through ack and the DONE cycle, then presents the next byte or drops.
   task automatic req_stream(input bit side, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) begin
         int   w;
         logic got;
         if (side) begin
            stb1  = 1'b1;
            data1 = base + 8'(k);
         end else begin
            stb0  = 1'b1;
            data0 = base + 8'(k);
         end
         w   = 0;
         got = 1'b0;
         while (!got && w < 60) begin
            tick();
            w++;
            got = side ? ack1 : ack0;
         end
         check_eq($sformatf("req%0d_ack%0d", side, k), 32'(got), 1);
         tick();
      end
      if (side) stb1 = 1'b0;
      else stb0 = 1'b0;
   endtask

   task automatic pulse_sync();
      sync = 1'b1;
      tick();
      sync = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_ack0"}, 32'(ack0), 0);
      check_eq({pfx, "_ack1"}, 32'(ack1), 0);
      check_eq({pfx, "_ppu_stb"}, 32'(ppu_stb), 0);
      check_eq({pfx, "_ppu_data"}, 32'(ppu_data), 0);
      check_eq({pfx, "_mode"}, 32'(mode), 0);
      check_eq({pfx, "_err"}, 32'(err), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int t0;
   int exp_auto[14];
   int exp_d0[5];

   initial begin
      exp_auto = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0, 0, 1};
      exp_d0   = '{2, 3, 4, 5, 0};

      // Reset values
      repeat (3) tick();
      rst = 1'b0;
      check_reset_vals("rst");

      // Single transfer: ppu_stb at T+1, ack0 at T+3, exactly one ppu_stb
      ack_en = 1'b1;
      clear_mon();
      t0 = cyc + 1;
      req_stream(1'b0, 1, 8'hA5);
      repeat (6) tick();
      check_eq("single_n_stb", 32'(n_stb), 1);
      check_eq("single_data", 32'(mon_data.size() > 0 ? mon_data[0] : 8'h00), 32'hA5);
      check_eq("single_stb_lat", 32'(stb_cyc - t0), 1);
      check_eq("single_ack_lat", 32'(ack0_cyc - t0), 3);
      check_eq("single_n_ack1", 32'(n_ack1), 0);
      check_eq("single_stb_width", 32'(stb_run_max), 1);

      // PPU never acks
      ack_en = 1'b0;
      clear_mon();
      stb0  = 1'b1;
      data0 = 8'h5A;
`ifdef PPU_SCHED_TIMEOUT_EN
      begin
         int w;
         w = 0;
         while (!ack0 && w < 40) begin
            tick();
            w++;
         end
         check_eq("to_ack_seen", 32'(ack0), 1);
         check_eq("to_ack_lat", 32'(ack0_cyc - stb_cyc), 17);
         check_eq("to_err_set", 32'(err), 1);
         tick();
         stb0 = 1'b0;
         check_eq("to_err_sticky", 32'(err), 1);
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         check_eq("to_err_clr", 32'(err), 0);
         stb0  = 1'b1;
         data0 = 8'h77;
         repeat (4) tick();
      end
`else
      repeat (1000) tick();
      check_eq("hold_n_ack0", 32'(n_ack0), 0);
      check_eq("hold_n_stb", 32'(n_stb), 1);
      check_eq("hold_err", 32'(err), 0);
`endif

      // Reset while waiting for the PPU, then a normal transfer from requester 0
      data0 = 8'hC3;
      rst   = 1'b1;
      tick();
      check_reset_vals("rstwait");
      rst    = 1'b0;
      ack_en = 1'b1;
      clear_mon();
      t0 = cyc + 1;
      req_stream(1'b0, 1, 8'hC3);
      repeat (4) tick();
      check_eq("rstwait_n_stb", 32'(n_stb), 1);
      check_eq("rstwait_data", 32'(mon_data.size() > 0 ? mon_data[0] : 8'h00), 32'hC3);
      check_eq("rstwait_ack_lat", 32'(ack0_cyc - t0), 3);

      // Contention: pointer back at 1, so order is 0,1,0,1,...
      do_reset();
      clear_mon();
      fork
         req_stream(1'b0, 4, 8'h10);
         req_stream(1'b1, 4, 8'h20);
      join
      repeat (4) tick();
      check_eq("cont_n_grants", 32'(mon_gnt.size()), 8);
      check_eq("cont_n_data", 32'(mon_data.size()), 8);
      for (int i = 0; i < 8 && i < mon_gnt.size() && i < mon_data.size(); i++) begin
         check_eq($sformatf("cont_gnt%0d", i), 32'(mon_gnt[i]), 32'(i % 2));
         check_eq($sformatf("cont_data%0d", i), 32'(mon_data[i]),
                  32'(((i % 2) != 0 ? 8'h20 : 8'h10) + 8'(i / 2)));
      end
      check_eq("cont_both_ack", 32'(n_both), 0);
      check_eq("cont_stb_width", 32'(stb_run_max), 1);

      // Auto cycling, dwell 2; mode must hold between syncs
      auto_en = 1'b1;
      dwell   = 8'd2;
      for (int k = 0; k < 14; k++) begin
         pulse_sync();
         check_eq($sformatf("auto_sync%0d", k), 32'(mode), 32'(exp_auto[k]));
         repeat (2) tick();
         check_eq($sformatf("auto_hold%0d", k), 32'(mode), 32'(exp_auto[k]));
      end

      // dwell 0 behaves as 1: change on every sync
      dwell = 8'd0;
      for (int k = 0; k < 5; k++) begin
         pulse_sync();
         check_eq($sformatf("dw0_sync%0d", k), 32'(mode), 32'(exp_d0[k]));
         tick();
      end

      // Host override: last pending write wins and restarts the dwell count
      auto_en = 1'b0;
      repeat (3) begin
         pulse_sync();
         tick();
      end
      check_eq("ovr_pre", 32'(mode), 0);
      mode_wr    = 1'b1;
      mode_wdata = 3'd3;
      tick();
      mode_wr = 1'b0;
      tick();
      check_eq("ovr_mid3", 32'(mode), 0);
      mode_wr    = 1'b1;
      mode_wdata = 3'd6;
      tick();
      mode_wr = 1'b0;
      check_eq("ovr_mid6", 32'(mode), 0);
      pulse_sync();
      check_eq("ovr_apply", 32'(mode), 6);
      auto_en = 1'b1;
      dwell   = 8'd2;
      tick();
      pulse_sync();
      check_eq("ovr_cnt_reset", 32'(mode), 6);
      tick();
      pulse_sync();
      check_eq("ovr_wrap", 32'(mode), 0);
      auto_en = 1'b0;
      tick();
      mode_wr    = 1'b1;
      mode_wdata = 3'd2;
      sync       = 1'b1;
      tick();
      mode_wr = 1'b0;
      sync    = 1'b0;
      check_eq("ovr_coincident", 32'(mode), 2);
      repeat (2) tick();
      pulse_sync();
      check_eq("ovr_pend_cleared", 32'(mode), 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ppu_sched.md
# ppu_sched

Front-end controller for the PPU. It arbitrates two byte requesters (host stream and auxiliary seed source) onto the PPU's single input handshake. It also owns the PPU `mode` select, changing it only at frame boundaries, either by auto-cycling with a programmable dwell or by a host-written override. It sits between the pattern/seed sources and the PPU input, and is driven by the same `sync` that restarts the PPU's raster counters.

## Interface
- `MODE_LAST`, 5: highest mode in the auto-cycle; mode wraps from MODE_LAST to 0.
- `TIMEOUT`, 16: WAIT-state cycles before a missing PPU ack is abandoned (range 2..255).

- `clk`  in  1  system clock (pixel clock domain).
- `rst`  in  1  reset; synchronous, active-high.
- `sync`  in  1  one-cycle frame-start pulse.
- `data0`  in  8  requester 0 (host) byte.
- `stb0`  in  1  requester 0 strobe; held high until `ack0`.
- `ack0`  out  1  one-cycle accept pulse to requester 0.
- `data1`  in  8  requester 1 (aux) byte.
- `stb1`  in  1  requester 1 strobe; held high until `ack1`.
- `ack1`  out  1  one-cycle accept pulse to requester 1.
- `ppu_data`  out  8  byte to PPU `data_i`.
- `ppu_stb`  out  1  PPU `stb_i`; asserted exactly one cycle per byte.
- `ppu_ack`  in  1  PPU `ack_i`.
- `mode`  out  3  PPU mode select.
- `auto_en`  in  1  enables dwell-based mode cycling.
- `dwell`  in  8  frames per mode in auto; 0 behaves as 1.
- `mode_wr`  in  1  one-cycle host mode write.
- `mode_wdata`  in  3  host mode value.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.

## Operation
- Transfer FSM states:
  - IDLE: if any stb, choose grant, latch data into `ppu_data` → SEND.
  - SEND: `ppu_stb`=1 for this cycle only → WAIT.
  - WAIT: on `ppu_ack`=1 → DONE; on timeout → DONE with `err` set.
  - DONE: pulse granted ack → IDLE.
- `ppu_ack` is ignored outside WAIT.
- Round-robin arbitration:
  - Last-grant pointer resets to 1, so requester 0 wins the first contention.
  - With both stb high, grant the requester not granted last.
  - With a single request, grant it regardless of the pointer.
  - The pointer updates on every grant.
- Requester contract: stb stays high in the DONE cycle and drops the cycle after ack. IDLE never samples a stb during DONE, so a held stb cannot double-issue.
- A timed-out transfer still returns the requester ack; the byte is dropped.
- `err` priority: set beats `err_clr` in the same cycle.
- Mode sequencing is evaluated only on `sync`=1 cycles:
  - Pending host write present: `mode` ← pending value, `frame_cnt` ← 0, pending cleared.
  - Else if `auto_en` and `frame_cnt` ≥ max(dwell,1)−1: `mode` advances (MODE_LAST→0), `frame_cnt` ← 0.
  - Else `frame_cnt` increments, saturating at 255.
- `mode_wr` latches `mode_wdata` into pending, clamped to 7. A later write before `sync` overwrites it.
- `mode_wr` and `sync` in the same cycle: the new value applies at that `sync`.
- `mode` never changes except on a `sync` cycle.
- Mode changes and transfers are independent; an in-flight byte is not aborted by a mode change.

## Timing
- Reset values: `ack0`=`ack1`=0, `ppu_stb`=0, `ppu_data`=0, `mode`=0, `err`=0; FSM IDLE, `frame_cnt`=0, pending empty, pointer=1.
- Reset mid-transfer abandons the byte with no ack; `ppu_stb` is low on the first cycle after `rst`.
- Nominal transfer: stb seen at T; `ppu_stb` high at T+1; `ppu_ack` at T+2; ack at T+3; next grant no earlier than T+4. Throughput is one byte per 4 cycles.
- Timeout fires when WAIT has lasted TIMEOUT cycles without `ppu_ack`; ack follows one cycle later.
- All outputs are registered; no combinational input→output path.

## Configuration
- `PPU_SCHED_TIMEOUT_EN` defined: WAIT timeout counter and `err` logic are present as described.
- Undefined:
  - WAIT holds indefinitely until `ppu_ack`.
  - `err` is tied 0; `err_clr` is ignored.
  - `TIMEOUT` is unused.

## Test plan
- Single transfer: `stb0`=1, `data0`=0xA5, PPU model acks one cycle after its stb. Expect `ppu_stb` for exactly 1 cycle with `ppu_data`=0xA5, then `ack0` at T+3, and no second `ppu_stb`.
- Contention: `stb0` and `stb1` both held for 4 bytes each. Expect grant order 0,1,0,1,0,1,0,1, with no ack on the non-granted side.
- Auto cycling: `auto_en`=1, `dwell`=2, 14 sync pulses. Expect `mode` 0,0,1,1,…,5,5,0 changing only on `sync` cycles. Then set `dwell`=0 and expect a change on every sync.
- Host override: `mode_wr` with 3 mid-frame, then 6 before `sync`. Expect `mode`=6 at the next sync and `frame_cnt` reset. Also `mode_wr`=2 coincident with `sync` → `mode`=2 that cycle.
- Timeout (macro on, TIMEOUT=16): PPU model never acks. Expect `ack0` exactly 17 cycles after `ppu_stb` and `err`=1; `err_clr` then drops it. With the macro off, the FSM stays in WAIT for 1000 cycles and `err`=0.
- Reset in WAIT: `rst`=1 for 1 cycle. Expect all outputs at reset values, then normal transfer from requester 0.
